// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, frame FSM states and delta saturation helper for the PS/2 mouse receiver
package ps2_pkg;
    localparam int PS2_FRAME_BITS = 11;
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} frame_state_e;
    function automatic logic signed [31:0] sat_shift(input logic signed [8:0] x9, input int shift, input int width);
        logic signed [31:0] v, hi, lo;
        v = 32'(x9) <<< shift;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises the PS/2 pins and receives one 11-bit frame (start, 8 data, odd parity, stop)
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   prev_q, err_q, sclk, sdata, fall, ok;
    frame_state_e           state_q;
    logic [3:0]             cnt_q;
    logic [9:0]             sr_q;
    logic [TW-1:0]          to_q;

    assign sclk  = clk_sync_q[SYNC_STAGES-1];
    assign sdata = data_sync_q[SYNC_STAGES-1];
    assign fall  = prev_q & ~sclk;
    // after ten shifts sr_q holds {stop, parity, d7..d0}
    assign ok    = sr_q[9] & (^sr_q[8:0]);
    assign byte_valid_o = (state_q == CHECK) & ok;
    assign frame_err_o  = err_q | ((state_q == CHECK) & ~ok);
    assign byte_data_o  = sr_q[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            prev_q      <= 1'b1;
            err_q       <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            to_q        <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
            prev_q      <= sclk;
            err_q       <= 1'b0;
            to_q        <= (fall || state_q != SHIFT) ? '0 : to_q + 1'b1;
            case (state_q)
                IDLE: if (fall && !sdata) begin
                    state_q <= SHIFT;
                    cnt_q   <= '0;
                end
                SHIFT: if (fall) begin
                    sr_q    <= {sdata, sr_q[9:1]};
                    cnt_q   <= cnt_q + 4'd1;
                    state_q <= (cnt_q == 4'(PS2_FRAME_BITS - 2)) ? CHECK : SHIFT;
                end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/ps2_mouse_packet_rx.sv
// ps2_mouse_packet_rx: assembles PS/2 mouse packets into scaled, saturated deltas and button states
module ps2_mouse_packet_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int WHEEL_EN       = 0,
    parameter int SCALE_SHIFT    = 0,
    parameter int OUT_W          = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ps2_clk_i,
    input  logic             ps2_data_i,
    output logic             pkt_valid_o,
    output logic [OUT_W-1:0] dx_o,
    output logic [OUT_W-1:0] dy_o,
    output logic [3:0]       dz_o,
    output logic             btn_l_o,
    output logic             btn_r_o,
    output logic             btn_m_o,
    output logic             frame_err_o,
    output logic             sync_err_o
);
    localparam logic [1:0] LAST = (WHEEL_EN != 0) ? 2'd3 : 2'd2;
    logic             byte_valid, frame_err, last;
    logic [7:0]       byte_data, b1_q, b2_q, y_byte;
    logic [6:0]       flags_q;
    logic [1:0]       idx_q;
    logic signed [8:0] x9, y9;
    logic [OUT_W-1:0] dx_d, dy_d;

    ps2_frame_rx #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_frame (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk_i    (ps2_clk_i),
        .ps2_data_i   (ps2_data_i),
        .byte_valid_o (byte_valid),
        .byte_data_o  (byte_data),
        .frame_err_o  (frame_err)
    );

    // flags_q is byte0 without the always-one sync bit: {y_ovf, x_ovf, y_sign, x_sign, m, r, l}
    always_comb begin
        last   = byte_valid && idx_q == LAST;
        y_byte = (WHEEL_EN != 0) ? b2_q : byte_data;
        x9     = flags_q[5] ? (flags_q[3] ? -9'sd255 : 9'sd255) : {flags_q[3], b1_q};
        y9     = flags_q[6] ? (flags_q[4] ? -9'sd255 : 9'sd255) : {flags_q[4], y_byte};
        dx_d   = OUT_W'(sat_shift(x9, SCALE_SHIFT, OUT_W));
        dy_d   = OUT_W'(sat_shift(y9, SCALE_SHIFT, OUT_W));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q       <= '0;
            flags_q     <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
            pkt_valid_o <= 1'b0;
            dx_o        <= '0;
            dy_o        <= '0;
            dz_o        <= '0;
            btn_l_o     <= 1'b0;
            btn_r_o     <= 1'b0;
            btn_m_o     <= 1'b0;
            frame_err_o <= 1'b0;
            sync_err_o  <= 1'b0;
        end else begin
            pkt_valid_o <= 1'b0;
            sync_err_o  <= 1'b0;
            frame_err_o <= frame_err;
            if (frame_err) begin
                idx_q <= '0;
            end else if (byte_valid) begin
                if (idx_q == 2'd0 && !byte_data[3]) begin
                    sync_err_o <= 1'b1;
                end else begin
                    if (idx_q == 2'd0) flags_q <= {byte_data[7:4], byte_data[2:0]};
                    if (idx_q == 2'd1) b1_q <= byte_data;
                    if (idx_q == 2'd2) b2_q <= byte_data;
                    idx_q <= last ? 2'd0 : idx_q + 2'd1;
                    if (last) begin
                        pkt_valid_o <= 1'b1;
                        dx_o        <= dx_d;
                        dy_o        <= dy_d;
                        dz_o        <= (WHEEL_EN != 0) ? byte_data[3:0] : 4'd0;
                        btn_l_o     <= flags_q[0];
                        btn_r_o     <= flags_q[1];
                        btn_m_o     <= flags_q[2];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// tb_ps2_mouse_packet_rx: directed PS/2 packet stimulus against three parameterisations of the receiver
`timescale 1ns/1ps
module tb_ps2_mouse_packet_rx;
    localparam int TO   = 200;
    localparam int HALF = 40;

    logic clk = 1'b0, reset = 1'b1, ps2c = 1'b1, ps2d = 1'b1, wsel = 1'b0;
    logic std_c, std_d, w_c, w_d;
    logic pv, bl, br, bm, fe, se;
    logic signed [9:0] dx, dy;
    logic signed [3:0] dz;
    logic pv2, bl2, br2, bm2, fe2, se2;
    logic signed [9:0] dx2, dy2;
    logic signed [3:0] dz2;
    logic pvw, blw, brw, bmw, few, sew;
    logic signed [9:0] dxw, dyw;
    logic signed [3:0] dzw;
    int checks = 0, passes = 0;
    int cyc = 0, pv_n = 0, fe_n = 0, se_n = 0, pvw_n = 0, pv_cyc = 0, stop_cyc = 0;

    always #500 clk = ~clk;
    assign std_c = wsel ? 1'b1 : ps2c;
    assign std_d = wsel ? 1'b1 : ps2d;
    assign w_c   = wsel ? ps2c : 1'b1;
    assign w_d   = wsel ? ps2d : 1'b1;

    ps2_mouse_packet_rx #(.TIMEOUT_CYCLES(TO), .WHEEL_EN(0), .SCALE_SHIFT(1), .OUT_W(10)) dut (
        .clk(clk), .reset(reset), .ps2_clk_i(std_c), .ps2_data_i(std_d), .pkt_valid_o(pv),
        .dx_o(dx), .dy_o(dy), .dz_o(dz), .btn_l_o(bl), .btn_r_o(br), .btn_m_o(bm),
        .frame_err_o(fe), .sync_err_o(se));
    ps2_mouse_packet_rx #(.TIMEOUT_CYCLES(TO), .WHEEL_EN(0), .SCALE_SHIFT(2), .OUT_W(10)) dut2 (
        .clk(clk), .reset(reset), .ps2_clk_i(std_c), .ps2_data_i(std_d), .pkt_valid_o(pv2),
        .dx_o(dx2), .dy_o(dy2), .dz_o(dz2), .btn_l_o(bl2), .btn_r_o(br2), .btn_m_o(bm2),
        .frame_err_o(fe2), .sync_err_o(se2));
    ps2_mouse_packet_rx #(.TIMEOUT_CYCLES(TO), .WHEEL_EN(1), .SCALE_SHIFT(1), .OUT_W(10)) dutw (
        .clk(clk), .reset(reset), .ps2_clk_i(w_c), .ps2_data_i(w_d), .pkt_valid_o(pvw),
        .dx_o(dxw), .dy_o(dyw), .dz_o(dzw), .btn_l_o(blw), .btn_r_o(brw), .btn_m_o(bmw),
        .frame_err_o(few), .sync_err_o(sew));

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (pv) begin
            pv_n = pv_n + 1;
            pv_cyc = cyc;
        end
        if (fe) fe_n = fe_n + 1;
        if (se) se_n = se_n + 1;
        if (pvw) pvw_n = pvw_n + 1;
    end

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2d = f[i];
            repeat (HALF) @(negedge clk);
            ps2c = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (HALF) @(negedge clk);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_pkt3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_frame(b0, 1'b0, 11);
        send_frame(b1, 1'b0, 11);
        send_frame(b2, 1'b0, 11);
    endtask

    task automatic test_reset;
        repeat (5) @(negedge clk);
        checks++;
        if ({pv, dx, dy, dz, bl, br, bm, fe, se} !== '0)
            $display("FAIL reset_std: got %h required 0", {pv, dx, dy, dz, bl, br, bm, fe, se});
        else passes++;
        checks++;
        if ({pvw, dxw, dyw, dzw, blw, brw, bmw, few, sew} !== '0)
            $display("FAIL reset_wheel: got %h required 0", {pvw, dxw, dyw, dzw, blw, brw, bmw, few, sew});
        else passes++;
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic;
        int p0, f0, s0;
        p0 = pv_n; f0 = fe_n; s0 = se_n;
        send_pkt3(8'h29, 8'h05, 8'hFB);
        checks++;
        if (pv_n - p0 !== 1) $display("FAIL basic_pulses: got %0d required 1", pv_n - p0); else passes++;
        checks++;
        if (pv_cyc - stop_cyc !== 4) $display("FAIL basic_latency: got %0d required 4", pv_cyc - stop_cyc); else passes++;
        checks++;
        if (dx !== 10) $display("FAIL basic_dx: got %0d required 10", dx); else passes++;
        checks++;
        if (dy !== -10) $display("FAIL basic_dy: got %0d required -10", dy); else passes++;
        checks++;
        if ({bm, br, bl} !== 3'b001) $display("FAIL basic_btn: got %b required 001", {bm, br, bl}); else passes++;
        checks++;
        if (fe_n != f0 || se_n != s0) $display("FAIL basic_errs: got %0d/%0d required 0/0", fe_n - f0, se_n - s0); else passes++;
        repeat (100) @(negedge clk);
        checks++;
        if (dx !== 10 || pv !== 1'b0) $display("FAIL basic_hold: got dx=%0d pv=%b required 10/0", dx, pv); else passes++;
    endtask

    task automatic test_overflow;
        send_pkt3(8'h58, 8'h10, 8'h00);
        checks++;
        if (dx !== -510) $display("FAIL ovf_dx: got %0d required -510", dx); else passes++;
        checks++;
        if (dy !== 0) $display("FAIL ovf_dy: got %0d required 0", dy); else passes++;
        checks++;
        if (dx2 !== -512) $display("FAIL ovf_dx_shift2: got %0d required -512", dx2); else passes++;
        checks++;
        if (dy2 !== 0) $display("FAIL ovf_dy_shift2: got %0d required 0", dy2); else passes++;
    endtask

    task automatic test_parity;
        int p0, f0;
        p0 = pv_n; f0 = fe_n;
        send_frame(8'h08, 1'b1, 11);
        checks++;
        if (fe_n - f0 !== 1) $display("FAIL parity_err: got %0d required 1", fe_n - f0); else passes++;
        checks++;
        if (pv_n != p0) $display("FAIL parity_no_pkt: got %0d required 0", pv_n - p0); else passes++;
        send_pkt3(8'h09, 8'h01, 8'h01);
        checks++;
        if (pv_n - p0 !== 1) $display("FAIL parity_next_pkt: got %0d required 1", pv_n - p0); else passes++;
        checks++;
        if (dx !== 2 || dy !== 2) $display("FAIL parity_next_d: got %0d,%0d required 2,2", dx, dy); else passes++;
    endtask

    task automatic test_sync;
        int p0, s0, f0;
        p0 = pv_n; s0 = se_n; f0 = fe_n;
        send_frame(8'h00, 1'b0, 11);
        checks++;
        if (se_n - s0 !== 1 || fe_n != f0) $display("FAIL sync_err: got %0d/%0d required 1/0", se_n - s0, fe_n - f0); else passes++;
        checks++;
        if (pv_n != p0) $display("FAIL sync_no_pkt: got %0d required 0", pv_n - p0); else passes++;
        send_pkt3(8'h0A, 8'h00, 8'h00);
        checks++;
        if (pv_n - p0 !== 1) $display("FAIL sync_next_pkt: got %0d required 1", pv_n - p0); else passes++;
        checks++;
        if ({bm, br, bl, dx, dy} !== {3'b010, 20'd0}) $display("FAIL sync_next_btn: got %b%b%b dx=%0d required 010 dx=0", bm, br, bl, dx); else passes++;
    endtask

    task automatic test_timeout;
        int p0, f0;
        p0 = pv_n; f0 = fe_n;
        send_frame(8'h00, 1'b0, 5);
        repeat (TO + 50) @(negedge clk);
        checks++;
        if (fe_n - f0 !== 1) $display("FAIL timeout_err: got %0d required 1", fe_n - f0); else passes++;
        send_pkt3(8'h1C, 8'h03, 8'h02);
        checks++;
        if (pv_n - p0 !== 1) $display("FAIL timeout_next_pkt: got %0d required 1", pv_n - p0); else passes++;
        checks++;
        if (dx !== -506 || dy !== 4) $display("FAIL timeout_next_d: got %0d,%0d required -506,4", dx, dy); else passes++;
        checks++;
        if ({bm, br, bl} !== 3'b100) $display("FAIL timeout_next_btn: got %b required 100", {bm, br, bl}); else passes++;
    endtask

    task automatic test_wheel;
        int p0;
        wsel = 1'b1;
        p0 = pvw_n;
        send_pkt3(8'h08, 8'h00, 8'h00);
        send_frame(8'h0F, 1'b0, 11);
        checks++;
        if (pvw_n - p0 !== 1) $display("FAIL wheel_pkt: got %0d required 1", pvw_n - p0); else passes++;
        checks++;
        if (dzw !== -1 || dxw !== 0 || dyw !== 0) $display("FAIL wheel_dz: got dz=%0d dx=%0d dy=%0d required -1,0,0", dzw, dxw, dyw); else passes++;
        send_frame(8'h08, 1'b0, 11);
        send_frame(8'h00, 1'b0, 11);
        send_frame(8'h00, 1'b0, 4);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({pvw, dxw, dyw, dzw, blw, brw, bmw, few, sew} !== '0)
            $display("FAIL wheel_reset: got %h required 0", {pvw, dxw, dyw, dzw, blw, brw, bmw, few, sew});
        else passes++;
        checks++;
        if ({pv, dx, dy, dz, bl, br, bm} !== '0) $display("FAIL std_reset_again: got %h required 0", {pv, dx, dy, dz, bl, br, bm}); else passes++;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        p0 = pvw_n;
        send_pkt3(8'h09, 8'h02, 8'h00);
        send_frame(8'h02, 1'b0, 11);
        checks++;
        if (pvw_n - p0 !== 1) $display("FAIL wheel_after_reset_pkt: got %0d required 1", pvw_n - p0); else passes++;
        checks++;
        if (dxw !== 4 || dyw !== 0 || dzw !== 2 || blw !== 1'b1)
            $display("FAIL wheel_after_reset_d: got dx=%0d dy=%0d dz=%0d l=%b required 4,0,2,1", dxw, dyw, dzw, blw);
        else passes++;
        wsel = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_overflow;
        test_parity;
        test_sync;
        test_timeout;
        test_wheel;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
